// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop sync + debounce per button channel, one-cycle
// press strobes, and the run/stop toggle register for the stopwatch core.

// One button channel: synchronizer, debounce counter, stable level, press strobe.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic hard_reset,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic accept
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             flip;

  // flip fires on the edge that completes DEBOUNCE_CYCLES consecutive mismatches;
  // accept is the rising case, shared with the run register in the top level
  assign mismatch = sync2 ^ level;
  assign flip     = mismatch && (cnt == CNT_MAX);
  assign accept   = flip && sync2;

  // two-flop synchronizer; the only reader of the raw button
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // debounce: count consecutive mismatching edges, adopt new level at the limit
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!mismatch) begin
      cnt   <= '0;
    end else if (flip) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // press strobe, high only on the edge where level rises
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) pulse <= 1'b0;
    else             pulse <= accept;
  end
endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic hard_reset,
  input  logic start_btn,
  input  logic clear_btn,
  output logic start_pulse,
  output logic clear_pulse,
  output logic start_level,
  output logic clear_level,
  output logic run
);
  localparam int NUM_CH = 2;  // channel 0 = start, channel 1 = clear

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] accept;

  assign raw = {clear_btn, start_btn};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk        (clk),
      .hard_reset (hard_reset),
      .raw        (raw[g]),
      .level      (level[g]),
      .pulse      (pulse[g]),
      .accept     (accept[g])
    );
  end

  assign start_pulse = pulse[0];
  assign clear_pulse = pulse[1];
  assign start_level = level[0];
  assign clear_level = level[1];

  // run/stop: clear wins over start; updates on the same edge as the strobes
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset)    run <= 1'b0;
    else if (accept[1]) run <= 1'b0;
    else if (accept[0]) run <= ~run;
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing buttons,
// every cycle compared against a sliding-window reference model.
module tb_btn_conditioner;
  localparam int N = 4;

  logic clk, hard_reset, start_btn, clear_btn;
  logic start_pulse, clear_pulse, start_level, clear_level, run;

  int n_vec = 0;
  int n_err = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk         (clk),
    .hard_reset  (hard_reset),
    .start_btn   (start_btn),
    .clear_btn   (clear_btn),
    .start_pulse (start_pulse),
    .clear_pulse (clear_pulse),
    .start_level (start_level),
    .clear_level (clear_level),
    .run         (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: raw samples delayed two edges, then a window of the last
  // N delayed samples; the level flips once the whole window disagrees with it
  bit hist [2][$];
  bit win  [2][$];
  bit m_level [2];
  bit m_pulse [2];
  bit m_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      hist[c].delete();
      win[c].delete();
      m_level[c] = 1'b0;
      m_pulse[c] = 1'b0;
    end
    m_run = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit c_in);
    bit raw [2];
    raw[0] = s;
    raw[1] = c_in;
    if (!hard_reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      bit seen, all_diff;
      seen = (hist[c].size() == 2) ? hist[c][0] : 1'b0;
      hist[c].push_back(raw[c]);
      if (hist[c].size() > 2) void'(hist[c].pop_front());
      win[c].push_back(seen);
      if (win[c].size() > N) void'(win[c].pop_front());
      all_diff = (win[c].size() == N);
      foreach (win[c][i]) if (win[c][i] == m_level[c]) all_diff = 1'b0;
      m_pulse[c] = all_diff && seen;
      if (all_diff) begin
        m_level[c] = seen;
        win[c].delete();
      end
    end
    if (m_pulse[1])      m_run = 1'b0;
    else if (m_pulse[0]) m_run = ~m_run;
  endtask

  task automatic chk_all();
    chk("start_pulse", start_pulse, m_pulse[0]);
    chk("clear_pulse", clear_pulse, m_pulse[1]);
    chk("start_level", start_level, m_level[0]);
    chk("clear_level", clear_level, m_level[1]);
    chk("run",         run,         m_run);
  endtask

  // drive buttons, take one edge, compare after it settles
  task automatic tick(input bit s, input bit c);
    start_btn = s;
    clear_btn = c;
    @(posedge clk);
    #1;
    model_edge(s, c);
    chk_all();
  endtask

  // asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset(input bit s, input bit c);
    hard_reset = 1'b0;
    #1;
    model_reset();
    chk_all();
    tick(s, c);
    hard_reset = 1'b1;
  endtask

  task automatic press(input bit s, input bit c, input int len);
    for (int i = 0; i < len; i++) tick(s, c);
  endtask

  initial begin
    int first, npulse, nboth, nlow, fall;
    bit seq [6];

    // 1: reset with both buttons high, then keep start held
    hard_reset = 1'b0; start_btn = 1'b1; clear_btn = 1'b1;
    model_reset();
    #2;
    chk_all();
    press(1, 1, 3);
    hard_reset = 1'b1;
    first = 0; npulse = 0;
    for (int n = 1; n <= 12; n++) begin
      tick(1, 0);
      if (start_pulse) begin
        npulse++;
        if (first == 0) first = n;
      end
    end
    chk("s1_latency", first, 6);
    chk("s1_npulse", npulse, 1);
    chk("s1_run", run, 1);
    chk("s1_level", start_level, 1);
    press(0, 0, 10);

    // 2: bounce then hold, from a fresh reset
    do_reset(0, 0);
    seq = '{1, 0, 1, 1, 0, 1};
    first = -1; npulse = 0;
    for (int i = 0; i < 18; i++) begin
      tick(i < 6 ? seq[i] : 1'b1, 0);
      if (start_pulse) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    chk("s2_pulse_idx", first, 10);
    chk("s2_npulse", npulse, 1);
    chk("s2_run", run, 1);
    press(0, 0, 10);

    // 3: three clean press/release cycles
    do_reset(0, 0);
    npulse = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        tick(1, 0);
        if (start_pulse) npulse++;
      end
      fall = 0;
      for (int i = 1; i <= 10; i++) begin
        tick(0, 0);
        if (start_pulse) npulse++;
        if (!start_level && fall == 0) fall = i;
      end
      chk("s3_fall", fall, 6);
    end
    chk("s3_npulse", npulse, 3);
    chk("s3_run", run, 1);

    // 4: long hold
    do_reset(0, 0);
    npulse = 0; nlow = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1, 0);
      if (start_pulse) npulse++;
      if (npulse > 0 && !run) nlow++;
    end
    chk("s4_npulse", npulse, 1);
    chk("s4_run_low", nlow, 0);
    press(0, 0, 10);

    // 5: priority, run=1 going in
    nboth = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1);
      if (start_pulse && clear_pulse) nboth++;
    end
    chk("s5_both", nboth, 1);
    chk("s5_run_both", run, 0);
    press(0, 0, 10);
    press(1, 0, 10);
    press(0, 0, 10);
    chk("s5_run_set", run, 1);
    press(0, 1, 10);
    press(0, 0, 10);
    chk("s5_clear_run1", run, 0);
    press(0, 1, 10);
    press(0, 0, 10);
    chk("s5_clear_run0", run, 0);

    // 6: reset mid-debounce with start still held
    npulse = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0);
      if (start_pulse) npulse++;
    end
    do_reset(1, 0);
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      tick(1, 0);
      if (start_pulse) begin
        npulse++;
        if (first == 0) first = n;
      end
    end
    chk("s6_latency", first, 6);
    chk("s6_npulse", npulse, 1);
    chk("s6_run", run, 1);
    press(0, 0, 10);

    // random bouncing on both buttons, occasional reset
    do_reset(0, 0);
    for (int seg = 0; seg < 150; seg++) begin
      bit s, c;
      int len;
      s   = 1'($urandom);
      c   = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 40) == 0) do_reset(s, c);
      press(s, c, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
